// File: rtl/perip_timecmp.sv
// Machine-timer peripheral: 64-bit microsecond mtime, staged 64-bit mtimecmp and a level irq.
// Defining PERIP_TIMECMP_MTIME_WRITE_EN adds staged bus writes to mtime (CTRL bit3 = t_staged).
`ifndef DATA_BUS
`define DATA_BUS [31:0]
`endif

module perip_timecmp #(
    parameter int unsigned CLK_DIV   = 50,
    parameter logic [63:0] CMP_RESET = 64'hffff_ffff_ffff_ffff
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic           rw,
    input  logic `DATA_BUS addr,
    output logic `DATA_BUS rdata,
    input  logic `DATA_BUS wdata,
    output logic           irq
);

    localparam logic [2:0]  SEL_MTIME_LO = 3'd0;
    localparam logic [2:0]  SEL_MTIME_HI = 3'd1;
    localparam logic [2:0]  SEL_CMP_LO   = 3'd2;
    localparam logic [2:0]  SEL_CMP_HI   = 3'd3;
    localparam logic [2:0]  SEL_CTRL     = 3'd4;
    localparam logic [15:0] PRE_MAX      = 16'(CLK_DIV - 1);

    logic [15:0] pre;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] stage_lo;
    logic [31:0] snap_hi;
    logic        cmp_staged;
    logic        irq_en;
    logic        pending;
    logic        t_bit;
    logic [2:0]  sel;
    logic        wr;
    logic        tick;
    logic        cond;
    logic        addr_unused;

    assign sel         = addr[4:2];
    assign wr          = ena & rw;
    assign tick        = (pre == PRE_MAX);
    assign cond        = (mtime >= mtimecmp);
    assign addr_unused = ^{addr[31:5], addr[1:0]};

`ifdef PERIP_TIMECMP_MTIME_WRITE_EN
    logic [31:0] stage_t;
    logic        t_staged;
    assign t_bit = t_staged;
`else
    assign t_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre        <= '0;
            mtime      <= '0;
            mtimecmp   <= CMP_RESET;
            stage_lo   <= '0;
            cmp_staged <= 1'b0;
            snap_hi    <= '0;
            irq_en     <= 1'b0;
            pending    <= 1'b0;
            irq        <= 1'b0;
`ifdef PERIP_TIMECMP_MTIME_WRITE_EN
            stage_t    <= '0;
            t_staged   <= 1'b0;
`endif
        end else begin
            pre <= tick ? 16'd0 : pre + 16'd1;
            if (tick) begin
                mtime <= mtime + 64'd1;
            end
`ifdef PERIP_TIMECMP_MTIME_WRITE_EN
            // Later assignments win, so a bus write overrides a same-cycle tick.
            if (wr && sel == SEL_MTIME_LO) begin
                stage_t  <= wdata;
                t_staged <= 1'b1;
            end
            if (wr && sel == SEL_MTIME_HI) begin
                mtime    <= t_staged ? {wdata, stage_t} : {wdata, mtime[31:0]};
                pre      <= '0;
                t_staged <= 1'b0;
            end
`endif
            // The high word is frozen when the low word is read so 64-bit reads never tear.
            if (ena && !rw && sel == SEL_MTIME_LO) begin
                snap_hi <= mtime[63:32];
            end
            if (wr && sel == SEL_CMP_LO) begin
                stage_lo   <= wdata;
                cmp_staged <= 1'b1;
            end
            if (wr && sel == SEL_CMP_HI) begin
                if (cmp_staged) begin
                    mtimecmp <= {wdata, stage_lo};
                end else begin
                    mtimecmp[63:32] <= wdata;
                end
                cmp_staged <= 1'b0;
            end
            if (wr && sel == SEL_CTRL) begin
                irq_en <= wdata[0];
            end
            // Stage boundary: compare result registered on current register values.
            pending <= cond;
            irq     <= irq_en & cond;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_MTIME_LO: rdata = mtime[31:0];
            SEL_MTIME_HI: rdata = snap_hi;
            SEL_CMP_LO:   rdata = mtimecmp[31:0];
            SEL_CMP_HI:   rdata = mtimecmp[63:32];
            SEL_CTRL:     rdata = {28'd0, t_bit, cmp_staged, pending, irq_en};
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_perip_timecmp.sv
// Bench for perip_timecmp (CLK_DIV = 4): register-map vector table plus timed corner sequences.
module tb_perip_timecmp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] rdata;
    logic [31:0] wdata = '0;
    logic        irq;

    int n_assert = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    perip_timecmp #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .rw(rw),
        .addr(addr), .rdata(rdata), .wdata(wdata), .irq(irq)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic check(input logic [31:0] act);
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        n_assert++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        ena = 1'b1; rw = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        ena = 1'b0; rw = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string n);
        ena = 1'b1; rw = 1'b0; addr = a;
        push(e, n);
        #1;
        check(rdata);
        @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] e, input string n);
        ena = 1'b0; addr = a;
        push(e, n);
        #1;
        check(rdata);
    endtask

    task automatic check_irq(input logic e, input string n);
        push({31'd0, e}, n);
        #1;
        check({31'd0, irq});
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h08, 32'h0, 32'hffff_ffff};
        vecs[1] = '{1'b0, 32'h0c, 32'h0, 32'hffff_ffff};
        vecs[2] = '{1'b0, 32'h10, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 32'h04, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 32'h14, 32'hdead_beef, 32'h0};
        vecs[5] = '{1'b0, 32'h14, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 32'h1c, 32'h1234_5678, 32'h0};
        vecs[7] = '{1'b0, 32'h1c, 32'h0, 32'h0};
        vecs[8] = '{1'b0, 32'h18, 32'h0, 32'h0};
        vecs[9] = '{1'b0, 32'h10, 32'h0, 32'h0};

        // Reset values, register map, and the 40-clock microsecond count.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rw) bus_write(vecs[i].addr, vecs[i].wdata);
            else bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end
        cyc(30);
        bus_read(32'h00, 32'd10, "mtime_after_40clk");
        check_irq(1'b0, "irq_after_reset");

        // Atomic commit with mtime = 100.
        cyc(360);
        bus_write(32'h10, 32'h1);
        bus_write(32'h08, 32'd5);
        check_irq(1'b0, "irq_after_stage");
        bus_read(32'h10, 32'h5, "ctrl_staged");
        bus_write(32'h0c, 32'h0);
        check_irq(1'b0, "irq_commit_cycle");
        bus_read(32'h10, 32'h1, "ctrl_after_commit");
        check_irq(1'b1, "irq_one_after_commit");
        peek(32'h10, 32'h3, "ctrl_pending");
        peek(32'h08, 32'd5, "cmp_lo_commit");
        peek(32'h0c, 32'h0, "cmp_hi_commit");

        // Equality edge: mtimecmp = 20.
        do_reset();
        bus_write(32'h10, 32'h1);
        bus_write(32'h08, 32'd20);
        bus_write(32'h0c, 32'h0);
        cyc(76);
        check_irq(1'b0, "irq_mtime19");
        peek(32'h00, 32'd19, "mtime19");
        cyc(1);
        check_irq(1'b0, "irq_tick_to_20");
        peek(32'h00, 32'd20, "mtime20");
        cyc(1);
        check_irq(1'b1, "irq_equal");

        // Gating by irq_en.
        bus_write(32'h10, 32'h0);
        check_irq(1'b1, "irq_en_clear_cycle");
        cyc(1);
        check_irq(1'b0, "irq_gated");
        peek(32'h10, 32'h2, "ctrl_gated_pending");
        bus_write(32'h10, 32'h1);
        check_irq(1'b0, "irq_en_set_cycle");
        cyc(1);
        check_irq(1'b1, "irq_regated");
        peek(32'h10, 32'h3, "ctrl_regated");

        // Second CMP_LO overwrites the staged word.
        bus_write(32'h08, 32'd1000);
        bus_write(32'h08, 32'd30);
        bus_write(32'h0c, 32'h0);
        peek(32'h08, 32'd30, "cmp_lo_overwrite");
        cyc(1);
        check_irq(1'b0, "irq_cmp_raised");
        peek(32'h10, 32'h1, "ctrl_cmp_raised");

        // Reset between CMP_LO and CMP_HI discards the staged word.
        bus_write(32'h08, 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_write(32'h0c, 32'h0);
        peek(32'h08, 32'hffff_ffff, "cmp_lo_after_rst");
        peek(32'h0c, 32'h0, "cmp_hi_after_rst");
        peek(32'h10, 32'h0, "ctrl_after_rst");

`ifdef PERIP_TIMECMP_MTIME_WRITE_EN
        // Tear-free read across a low-word carry.
        do_reset();
        bus_write(32'h00, 32'hffff_fffe);
        peek(32'h10, 32'h8, "ctrl_t_staged");
        bus_write(32'h04, 32'h0);
        peek(32'h10, 32'h0, "ctrl_t_commit");
        bus_read(32'h00, 32'hffff_fffe, "mtime_lo_snap");
        cyc(12);
        bus_read(32'h04, 32'h0, "mtime_hi_snapshot");
        peek(32'h00, 32'h1, "mtime_lo_live");

        // Wrap from all-ones drops irq.
        bus_write(32'h10, 32'h1);
        bus_write(32'h00, 32'hffff_ffff);
        bus_write(32'h04, 32'hffff_ffff);
        cyc(1);
        check_irq(1'b1, "irq_all_ones");
        cyc(3);
        check_irq(1'b1, "irq_before_wrap");
        peek(32'h00, 32'h0, "mtime_wrapped");
        cyc(1);
        check_irq(1'b0, "irq_after_wrap");
`else
        // MTIME writes are ignored in the default build.
        bus_write(32'h00, 32'd123);
        bus_write(32'h04, 32'd5);
        peek(32'h10, 32'h0, "ctrl_no_t_staged");
        peek(32'h00, 32'h0, "mtime_lo_unwritten");
        bus_read(32'h00, 32'h0, "mtime_lo_read");
        peek(32'h04, 32'h0, "mtime_hi_unwritten");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
